spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
//  Peripheral-side SPI engine: the counterpart to the master-side SCLK/sample generator.
//  Oversamples external sclk/ss_n/mosi in the clk_i domain.
//  Shifts DATA_W-bit words in on mosi and out on miso, for any CPOL/CPHA.
//  Exposes valid/ready word interfaces to the APB register file.
// PARAMETERS
//  DATA_W       8  word width in bits (>=2)
//  SYNC_STAGES  2  synchronizer flops on sclk_i, ss_n_i, mosi_i (>=2)
// PORTS
//  clk_i       in   1       system clock; must be >= 4x sclk frequency
//  rst_i       in   1       synchronous, active-high reset
//  cpol        in   1       clock idle level; stable while busy_o=1
//  cpha        in   1       0: sample on leading edge, 1: sample on trailing edge; stable while busy_o=1
//  sclk_i      in   1       serial clock from master (async)
//  ss_n_i      in   1       slave select, active low (async)
//  mosi_i      in   1       serial data in (async)
//  miso_o      out  1       serial data out
//  miso_oe_o   out  1       miso drive enable (1 while selected)
//  tx_data_i   in   DATA_W  next word to transmit
//  tx_valid_i  in   1       tx_data_i valid
//  tx_ready_o  out  1       1-deep tx holding register empty
//  rx_data_o   out  DATA_W  last received word
//  rx_valid_o  out  1       rx_data_o unread
//  rx_ready_i  in   1       consumer accepts rx_data_o
//  busy_o      out  1       FSM in ACTIVE
//  overrun_o   out  1       sticky: word completed while rx_valid_o=1 and no rx_ready_i
//  underrun_o  out  1       sticky: word started with tx holding register empty
//  clr_err_i   in   1       clears overrun_o/underrun_o (wins over a same-cycle set)
// BEHAVIOUR
//  Reset: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, busy_o=0, flags=0.
//  Reset: sync chains load ss_n=1, sclk=cpol, mosi=0.
//  Edges: s_sclk = sync output; edge = s_sclk != s_sclk_d.
//  Leading edge = transition away from cpol; trailing edge = transition back to cpol.
//  Edges are ignored in IDLE.
//  FSM IDLE->ACTIVE on synced ss_n=0:
//   - bit_cnt=0; tx shreg loaded from holding reg (tx_ready_o->1).
//   - If holding reg empty, tx shreg loads 0 and underrun_o is set.
//  FSM ACTIVE->IDLE on synced ss_n=1 (any cycle, including mid-word):
//   - Partial rx word is discarded; no rx_valid_o.
//   - bit_cnt is cleared; holding reg is untouched.
//  Sample edge (cpha=0 leading, cpha=1 trailing): rx shreg shifts in s_mosi; bit_cnt++.
//  Shift edge (the other edge): tx shreg shifts.
//   - cpha=1: the first leading edge of each word does not shift.
//   - cpha=0: the trailing edge after bit DATA_W-1 loads the next word instead of shifting.
//   - cpha=1: the next word is loaded on the final trailing (sample) edge.
//  miso_o = tx shreg MSB (registered); miso_oe_o = busy_o.
//  Word done: on the sample edge where bit_cnt==DATA_W-1.
//   - rx_data_o <= assembled word and rx_valid_o <= 1 on that same clk_i edge.
//   - Latency: SYNC_STAGES+1 clk_i edges after the pin transition.
//   - bit_cnt wraps to 0; back-to-back words continue without ss_n deassertion.
//  rx handshake: rx_valid_o clears on rx_valid_o & rx_ready_i.
//   - Completion with rx_valid_o=1 and no rx_ready_i: data overwritten, overrun_o set.
//   - Completion with rx_ready_i in the same cycle: no overrun; rx_valid_o stays 1 with the new word.
//  tx handshake: accept when tx_valid_i & tx_ready_o.
//   - An accept and a word-load in the same cycle: the load takes the old content; the new word is held, tx_ready_o=0.
// CONFIGURATION
//  SPI_SLAVE_LSBFE_EN defined:
//   - Adds input lsbfe_i (1 bit); must be stable while busy_o=1.
//   - lsbfe_i=1: shift LSB first on both miso and mosi (tx out from bit 0, rx in at MSB, shifting right).
//  SPI_SLAVE_LSBFE_EN undefined: no lsbfe_i port; MSB first always.
// TESTING
//  - Reset: assert rst_i 2 cycles mid-word -> all outputs at reset values; busy_o=0; no rx_valid_o.
//  - Mode 0 (cpol=0, cpha=0), sclk=clk/8, tx 0xA5, master sends 0x3C:
//    -> rx_data_o=0x3C with rx_valid_o=1; master receives 0xA5.
//  - Modes 1/2/3, tx 0x81, master sends 0x7E -> each mode exchanges correctly; miso changes only on shift edges.
//  - Back-to-back 0x11, 0x22 in one ss_n frame with tx preloaded -> two rx_valid_o events; miso shows 0x11 then 0x22.
//  - Second word completes before rx_ready_i -> overrun_o=1; rx_data_o = second word.
//  - Empty tx holding reg -> miso sends 0x00, underrun_o=1; clr_err_i clears both flags.
//  - ss_n deasserted after 3 bits -> no rx_valid_o, busy_o=0 within SYNC_STAGES+1 cycles.
//  - Next frame starts from bit 0.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI peripheral engine: oversamples sclk/ss_n/mosi in the clk_i domain, any CPOL/CPHA,
// with valid/ready word ports. Define SPI_SLAVE_LSBFE_EN to add the lsbfe_i (LSB-first) input.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_SLAVE_LSBFE_EN
  input  logic              lsbfe_i,
`endif
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o,
  input  logic              clr_err_i
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   s_sclk;
  logic                   s_sclk_d;
  logic                   s_ss_n;
  logic                   s_mosi;

  logic [0:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shreg;
  logic [DATA_W-1:0] rx_shreg;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  logic              lsb_first;
  logic              active;
  logic              sclk_edge;
  logic              leading;
  logic              trailing;
  logic              sample_edge;
  logic              shift_edge;
  logic              start;
  logic              stop;
  logic              word_done;
  logic              load;
  logic              do_shift;
  logic              accept;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_shifted;

`ifdef SPI_SLAVE_LSBFE_EN
  assign lsb_first = lsbfe_i;
`else
  assign lsb_first = 1'b0;
`endif

  // Synchronizer chains reset to the idle bus state so no false edge or select is seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= {SYNC_STAGES{cpol}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      s_sclk_d  <= cpol;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      s_sclk_d  <= s_sclk;
    end
  end

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_ss_n = ss_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];

  // A shift edge with bit_cnt==0 is either the idle first leading edge (cpha=1)
  // or the trailing edge right after the last bit (cpha=0), where the next word loads.
  always_comb begin
    active      = (state == ACTIVE);
    sclk_edge   = (s_sclk != s_sclk_d);
    leading     = sclk_edge & (s_sclk != cpol);
    trailing    = sclk_edge & (s_sclk == cpol);
    start       = ~active & ~s_ss_n;
    stop        = active & s_ss_n;
    sample_edge = active & ~s_ss_n & (cpha ? trailing : leading);
    shift_edge  = active & ~s_ss_n & (cpha ? leading : trailing);
    word_done   = sample_edge & (bit_cnt == LAST_BIT);
    do_shift    = shift_edge & (bit_cnt != '0);
    load        = start | (cpha ? word_done : (shift_edge & (bit_cnt == '0)));
    accept      = tx_valid_i & ~hold_full;
    rx_word     = lsb_first ? {s_mosi, rx_shreg[DATA_W-1:1]}
                            : {rx_shreg[DATA_W-2:0], s_mosi};
    tx_shifted  = lsb_first ? {1'b0, tx_shreg[DATA_W-1:1]}
                            : {tx_shreg[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shreg <= '0;
    end else begin
      if (start) begin
        state <= ACTIVE;
      end else if (stop) begin
        state <= IDLE;
      end
      if (start || stop) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (sample_edge) begin
        rx_shreg <= rx_word;
      end
    end
  end

  // A load in the same cycle as an accept takes the old holding content.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_shreg   <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (load) begin
        tx_shreg <= hold_full ? hold_data : '0;
      end else if (do_shift) begin
        tx_shreg <= tx_shifted;
      end
      if (accept) begin
        hold_data <= tx_data_i;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (clr_err_i) begin
        underrun_o <= 1'b0;
      end else if (load && !hold_full) begin
        underrun_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (word_done) begin
        rx_data_o  <= rx_word;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (clr_err_i) begin
        overrun_o <= 1'b0;
      end else if (word_done && rx_valid_o && !rx_ready_i) begin
        overrun_o <= 1'b1;
      end
    end
  end

  assign busy_o     = active;
  assign miso_oe_o  = active;
  assign miso_o     = lsb_first ? tx_shreg[0] : tx_shreg[DATA_W-1];
  assign tx_ready_o = ~hold_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: an SPI master model drives frames in every mode and a word-level
// reference (queues of sent/queued words) predicts what each side receives.
module tb_spi_slave_core;

  localparam int HALF = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cpol;
  logic       cpha;
  logic       sclk_i;
  logic       ss_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       busy_o;
  logic       overrun_o;
  logic       underrun_o;
  logic       clr_err_i;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] tx_feed[$];
  logic [7:0] rx_q[$];
  logic [7:0] mst_out[4];
  logic [7:0] mst_in[4];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[6];

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpol(cpol), .cpha(cpha),
    .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .underrun_o(underrun_o),
    .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Consumer side: every accepted rx word is captured for comparison.
  always @(posedge clk_i) begin
    if (rx_valid_o === 1'b1 && rx_ready_i === 1'b1) rx_q.push_back(rx_data_o);
  end

  // Producer side: feeds queued tx words into the holding register whenever it is free.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (tx_feed.size() > 0 && tx_ready_o === 1'b1 && rst_i === 1'b0) begin
        tx_data_i  = tx_feed[0];
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        void'(tx_feed.pop_front());
        tx_valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int k);
    if (k < rx_q.size()) return rx_q[k];
    return 8'hxx;
  endfunction

  task automatic apply_reset();
    sclk_i = cpol;
    rst_i  = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic frame_begin();
    ss_n_i = 1'b0;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic frame_word(input int idx, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi_i = mst_out[idx][7-b];
        repeat (HALF) @(negedge clk_i);
        mst_in[idx][7-b] = miso_o;
        sclk_i = ~cpol;
        repeat (HALF) @(negedge clk_i);
        sclk_i = cpol;
      end else begin
        sclk_i = ~cpol;
        mosi_i = mst_out[idx][7-b];
        repeat (HALF) @(negedge clk_i);
        mst_in[idx][7-b] = miso_o;
        sclk_i = cpol;
        repeat (HALF) @(negedge clk_i);
      end
    end
  endtask

  task automatic frame_end();
    repeat (HALF) @(negedge clk_i);
    ss_n_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_miso_oe"}, 32'(miso_oe_o), 32'd0);
    check({tag, "_miso"}, 32'(miso_o), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
    check({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data_o), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_o), 32'd0);
    check({tag, "_underrun"}, 32'(underrun_o), 32'd0);
  endtask

  initial begin
    int nwords;
    int nfeed;
    logic [7:0] fw[4];

    rst_i = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk_i = 1'b0; ss_n_i = 1'b1;
    mosi_i = 1'b0; rx_ready_i = 1'b1; clr_err_i = 1'b0;

    vecs[0] = '{cpol:1'b0, cpha:1'b0, tx:8'hA5, mosi:8'h3C, exp_rx:8'h3C, exp_miso:8'hA5};
    vecs[1] = '{cpol:1'b0, cpha:1'b1, tx:8'h81, mosi:8'h7E, exp_rx:8'h7E, exp_miso:8'h81};
    vecs[2] = '{cpol:1'b1, cpha:1'b0, tx:8'h81, mosi:8'h7E, exp_rx:8'h7E, exp_miso:8'h81};
    vecs[3] = '{cpol:1'b1, cpha:1'b1, tx:8'h81, mosi:8'h7E, exp_rx:8'h7E, exp_miso:8'h81};
    vecs[4] = '{cpol:1'b1, cpha:1'b1, tx:8'hF0, mosi:8'h0F, exp_rx:8'h0F, exp_miso:8'hF0};
    vecs[5] = '{cpol:1'b0, cpha:1'b0, tx:8'h01, mosi:8'h80, exp_rx:8'h80, exp_miso:8'h01};

    apply_reset();
    check_reset_outputs("init");

    // Table of single-word exchanges in every mode.
    for (int i = 0; i < 6; i++) begin
      cpol = vecs[i].cpol;
      cpha = vecs[i].cpha;
      apply_reset();
      tx_feed.push_back(vecs[i].tx);
      repeat (6) @(negedge clk_i);
      rx_q.delete();
      mst_out[0] = vecs[i].mosi;
      frame_begin();
      check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'd1);
      frame_word(0, 8);
      frame_end();
      check($sformatf("vec%0d_rx_count", i), 32'(rx_q.size()), 32'd1);
      check($sformatf("vec%0d_rx", i), 32'(rx_at(0)), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_miso", i), 32'(mst_in[0]), 32'(vecs[i].exp_miso));
      check($sformatf("vec%0d_idle", i), 32'(busy_o), 32'd0);
    end

    // Reset held two cycles in the middle of a word.
    cpol = 1'b0; cpha = 1'b0;
    apply_reset();
    tx_feed.push_back(8'h5A);
    repeat (6) @(negedge clk_i);
    rx_q.delete();
    mst_out[0] = 8'hC3;
    frame_begin();
    frame_word(0, 3);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("rst_mid1");
    @(negedge clk_i);
    rst_i = 1'b0;
    ss_n_i = 1'b1;
    check_reset_outputs("rst_mid2");
    repeat (8) @(negedge clk_i);
    check("rst_mid_busy_after", 32'(busy_o), 32'd0);
    check("rst_mid_no_rx", 32'(rx_q.size()), 32'd0);

    // Back-to-back words in one frame with the holding register refilled.
    cpol = 1'b0; cpha = 1'b1;
    apply_reset();
    tx_feed.push_back(8'h11);
    tx_feed.push_back(8'h22);
    repeat (6) @(negedge clk_i);
    rx_q.delete();
    mst_out[0] = 8'hC3;
    mst_out[1] = 8'h5A;
    frame_begin();
    frame_word(0, 8);
    frame_word(1, 8);
    frame_end();
    check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    check("b2b_rx0", 32'(rx_at(0)), 32'hC3);
    check("b2b_rx1", 32'(rx_at(1)), 32'h5A);
    check("b2b_miso0", 32'(mst_in[0]), 32'h11);
    check("b2b_miso1", 32'(mst_in[1]), 32'h22);

    // Overrun: second word completes while the first is still unread.
    cpol = 1'b0; cpha = 1'b0;
    apply_reset();
    rx_ready_i = 1'b0;
    tx_feed.push_back(8'h33);
    tx_feed.push_back(8'h44);
    repeat (6) @(negedge clk_i);
    mst_out[0] = 8'h12;
    mst_out[1] = 8'h34;
    frame_begin();
    frame_word(0, 8);
    frame_word(1, 8);
    frame_end();
    check("ovr_flag", 32'(overrun_o), 32'd1);
    check("ovr_rx_valid", 32'(rx_valid_o), 32'd1);
    check("ovr_rx_data", 32'(rx_data_o), 32'h34);
    check("ovr_miso1", 32'(mst_in[1]), 32'h44);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    check("ovr_rx_cleared", 32'(rx_valid_o), 32'd0);

    // Underrun: empty holding register sends zeros; clr_err clears both flags.
    rx_ready_i = 1'b1;
    rx_q.delete();
    mst_out[0] = 8'hE7;
    frame_begin();
    frame_word(0, 8);
    frame_end();
    check("udr_miso", 32'(mst_in[0]), 32'h00);
    check("udr_rx", 32'(rx_at(0)), 32'hE7);
    check("udr_flag", 32'(underrun_o), 32'd1);
    check("udr_ovr_sticky", 32'(overrun_o), 32'd1);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    check("clr_overrun", 32'(overrun_o), 32'd0);
    check("clr_underrun", 32'(underrun_o), 32'd0);

    // Abort after 3 bits, then a full frame must start from bit 0.
    apply_reset();
    tx_feed.push_back(8'h3F);
    repeat (6) @(negedge clk_i);
    rx_q.delete();
    mst_out[0] = 8'hFF;
    frame_begin();
    frame_word(0, 3);
    ss_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_miso_oe", 32'(miso_oe_o), 32'd0);
    repeat (6) @(negedge clk_i);
    check("abort_no_rx", 32'(rx_q.size()), 32'd0);
    tx_feed.push_back(8'h96);
    repeat (6) @(negedge clk_i);
    mst_out[0] = 8'h69;
    frame_begin();
    frame_word(0, 8);
    frame_end();
    check("after_abort_rx_count", 32'(rx_q.size()), 32'd1);
    check("after_abort_rx", 32'(rx_at(0)), 32'h69);
    check("after_abort_miso", 32'(mst_in[0]), 32'h96);

    // Randomized frames against the word-level reference.
    for (int it = 0; it < 20; it++) begin
      cpol   = 1'($urandom);
      cpha   = 1'($urandom);
      nwords = int'($urandom_range(1, 3));
      nfeed  = int'($urandom_range(0, nwords + 1));
      apply_reset();
      for (int k = 0; k < nfeed; k++) begin
        fw[k] = 8'($urandom);
        tx_feed.push_back(fw[k]);
      end
      for (int k = 0; k < nwords; k++) mst_out[k] = 8'($urandom);
      repeat (6) @(negedge clk_i);
      rx_q.delete();
      frame_begin();
      for (int k = 0; k < nwords; k++) frame_word(k, 8);
      frame_end();
      check($sformatf("rnd%0d_rx_count", it), 32'(rx_q.size()), 32'(nwords));
      for (int k = 0; k < nwords; k++) begin
        check($sformatf("rnd%0d_rx%0d", it, k), 32'(rx_at(k)), 32'(mst_out[k]));
        check($sformatf("rnd%0d_miso%0d", it, k), 32'(mst_in[k]),
              (k < nfeed) ? 32'(fw[k]) : 32'd0);
      end
      if (nfeed == 0) check($sformatf("rnd%0d_underrun", it), 32'(underrun_o), 32'd1);
      if (nfeed > nwords) check($sformatf("rnd%0d_no_underrun", it), 32'(underrun_o), 32'd0);
      check($sformatf("rnd%0d_no_overrun", it), 32'(overrun_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
